// File: rtl/cpu_trace_buffer_if.sv
// rtl/cpu_trace_buffer_if.sv - retire capture and drain handshake bundle for the trace buffer
interface cpu_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_wb;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_wb;

  modport master (
    output cap_valid, cap_pc, cap_wb, rd_ready,
    input  rd_valid, rd_pc, rd_wb
  );

  modport slave (
    input  cap_valid, cap_pc, cap_wb, rd_ready,
    output rd_valid, rd_pc, rd_wb
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - retire-trace capture buffer with PC trigger, wrap/stop modes and drain port
module cpu_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0,
  parameter int OVW   = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                arm,
  input  logic                stop,
  input  logic                trig_en,
  input  logic [XLEN-1:0]     trig_pc,
  input  logic [AW:0]         post_cnt,
  cpu_trace_buffer_if.slave   trace,
  output logic [AW:0]         count,
  output logic [OVW-1:0]      overflow_cnt,
  output logic [1:0]          state,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       remain_q, remain_d;
  logic [OVW-1:0]    ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              wr_en;
  logic              cap_take;
  logic              full;
  logic              rd_valid;
  logic [2*XLEN-1:0] rd_entry;

  logic [2*XLEN-1:0] mem_q [DEPTH];

  assign full = (count_q == CNT_FULL);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    remain_d = remain_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    cap_take = 1'b0;

    if (arm) begin
      state_d  = S_CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      remain_d = '0;
      ovf_d    = '0;
    end else begin
      case (state_q)
        S_CAPTURE, S_POST: begin
          if (stop) begin
            state_d = S_DRAIN;
          end else if (trace.cap_valid) begin
            cap_take = 1'b1;
            if (state_q == S_CAPTURE) begin
              // The trigger sample itself goes through the write rule, even when dropped.
              if (trig_en && (trace.cap_pc == trig_pc)) begin
                remain_d = post_cnt;
                state_d  = (post_cnt == '0) ? S_DRAIN : S_POST;
              end
            end else begin
              remain_d = remain_q - 1'b1;
              if (remain_q == (AW+1)'(1)) state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (trace.rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (cap_take) begin
      if (!full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else begin
        // Full in wrap mode: the write slot is the oldest entry, so both pointers advance.
        if (WRAP != 0) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      remain_q <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= {trace.cap_pc, trace.cap_wb};
  end

  assign rd_valid       = (state_q == S_DRAIN) && (count_q != '0);
  assign rd_entry       = mem_q[rd_ptr_q];
  assign trace.rd_valid = rd_valid;
  assign trace.rd_pc    = rd_valid ? rd_entry[2*XLEN-1:XLEN] : '0;
  assign trace.rd_wb    = rd_valid ? rd_entry[XLEN-1:0] : '0;

  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer in stop-when-full and wrap modes
module tb_cpu_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm;
  logic        stop;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [2:0]  post_cnt;
  logic        rdy;

  logic [2:0]  count_a, count_b;
  logic [2:0]  ovf_a;
  logic [15:0] ovf_b;
  logic [1:0]  state_a, state_b;
  logic        done_a, done_b;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int          ova, ovb;
  int          ncmp, nerr;

  always #5 clock = ~clock;

  cpu_trace_buffer_if #(.XLEN(32)) ia ();
  cpu_trace_buffer_if #(.XLEN(32)) ib ();

  cpu_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(0), .OVW(3)) u_a (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_cnt(post_cnt), .trace(ia.slave), .count(count_a),
    .overflow_cnt(ovf_a), .state(state_a), .done(done_a)
  );

  cpu_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(1), .OVW(16)) u_b (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_cnt(post_cnt), .trace(ib.slave), .count(count_b),
    .overflow_cnt(ovf_b), .state(state_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cap(input logic v, input logic [31:0] pc);
    ia.cap_valid = v; ia.cap_pc = pc; ia.cap_wb = pc ^ 32'hDEAD_0000;
    ib.cap_valid = v; ib.cap_pc = pc; ib.cap_wb = pc ^ 32'hDEAD_0000;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    qa.delete(); qb.delete();
    ova = 0; ovb = 0;
  endtask

  task automatic cap(input logic [31:0] pc, input bit store, input bit with_stop);
    set_cap(1'b1, pc);
    stop = with_stop;
    step();
    set_cap(1'b0, 32'h0);
    stop = 1'b0;
    if (store) begin
      if (qa.size() < 4) qa.push_back({pc, pc ^ 32'hDEAD_0000});
      else ova++;
      qb.push_back({pc, pc ^ 32'hDEAD_0000});
      if (qb.size() > 4) begin
        void'(qb.pop_front());
        ovb++;
      end
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic chk_ovf();
    chk("a_overflow_cnt", 64'(ovf_a), (ova > 7) ? 64'd7 : 64'(ova));
    chk("b_overflow_cnt", 64'(ovf_b), 64'(ovb));
  endtask

  task automatic drain(input bit bp);
    int          cyc;
    logic [63:0] e;
    cyc = 0;
    while (!(state_a == 2'd0 && state_b == 2'd0) && cyc < 60) begin
      if (bp && cyc < 5) rdy = 1'b0;
      else if (bp)       rdy = cyc[0];
      else               rdy = 1'b1;
      ia.rd_ready = rdy;
      ib.rd_ready = rdy;
      #1;
      if (bp && cyc < 5) begin
        chk("bp_rd_valid", 64'(ia.rd_valid), 64'd1);
        chk("bp_rd_pc_stable", 64'(ia.rd_pc), 64'(qa[0][63:32]));
      end
      if (state_a == 2'd3) chk("a_rd_valid", 64'(ia.rd_valid), 64'(qa.size() != 0));
      if (ia.rd_valid && rdy) begin
        if (qa.size() == 0) chk("a_extra_pop", 64'd1, 64'd0);
        else begin
          e = qa.pop_front();
          chk("a_rd_pc", 64'(ia.rd_pc), 64'(e[63:32]));
          chk("a_rd_wb", 64'(ia.rd_wb), 64'(e[31:0]));
        end
      end
      if (ib.rd_valid && rdy) begin
        if (qb.size() == 0) chk("b_extra_pop", 64'd1, 64'd0);
        else begin
          e = qb.pop_front();
          chk("b_rd_pc", 64'(ib.rd_pc), 64'(e[63:32]));
          chk("b_rd_wb", 64'(ib.rd_wb), 64'(e[31:0]));
        end
      end
      step();
      cyc++;
    end
    rdy = 1'b0;
    ia.rd_ready = 1'b0;
    ib.rd_ready = 1'b0;
    chk("drain_in_budget", 64'(cyc < 60), 64'd1);
    chk("a_done_pulse", 64'(done_a), 64'd1);
    chk("b_done_pulse", 64'(done_b), 64'd1);
    chk("a_model_empty", 64'(qa.size()), 64'd0);
    chk("b_model_empty", 64'(qb.size()), 64'd0);
    step();
    chk("a_done_one_cycle", 64'(done_a), 64'd0);
    chk("a_idle_after_drain", 64'(state_a), 64'd0);
  endtask

  initial begin
    ncmp = 0; nerr = 0; ova = 0; ovb = 0;
    reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0;
    trig_pc = 32'h0; post_cnt = 3'd0; rdy = 1'b0;
    ia.rd_ready = 1'b0; ib.rd_ready = 1'b0;
    set_cap(1'b0, 32'h0);
    step(); step();
    reset = 1'b0;
    chk("rst_state", 64'(state_a), 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_rd_valid", 64'(ia.rd_valid), 64'd0);
    chk("rst_rd_pc", 64'(ia.rd_pc), 64'd0);
    chk("rst_done", 64'(done_b), 64'd0);

    cap(32'h40, 1'b0, 1'b0);
    chk("idle_ignores_cap", 64'(count_a), 64'd0);

    do_arm();
    chk("arm_state", 64'(state_a), 64'd1);
    for (int i = 0; i < 6; i++) cap(32'(i * 4), 1'b1, 1'b0);
    chk("a_count_full", 64'(count_a), 64'd4);
    chk("b_count_full", 64'(count_b), 64'd4);
    chk_ovf();
    do_stop();
    chk("stop_to_drain", 64'(state_a), 64'd3);
    drain(1'b0);

    trig_en = 1'b1; trig_pc = 32'h100; post_cnt = 3'd2;
    do_arm();
    cap(32'hF8, 1'b1, 1'b0);
    cap(32'hFC, 1'b1, 1'b0);
    cap(32'h100, 1'b1, 1'b0);
    chk("trig_to_post", 64'(state_a), 64'd2);
    cap(32'h104, 1'b1, 1'b0);
    chk("post_remain", 64'(state_b), 64'd2);
    cap(32'h108, 1'b1, 1'b0);
    chk("post_to_drain", 64'(state_a), 64'd3);
    cap(32'h10C, 1'b0, 1'b0);
    chk("drain_ignores_cap", 64'(count_a), 64'd4);
    chk_ovf();
    drain(1'b0);

    trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 3; i++) cap(32'h200 + 32'(i * 4), 1'b1, 1'b0);
    do_stop();
    drain(1'b1);

    do_arm();
    for (int i = 0; i < 5; i++) cap(32'h300 + 32'(i * 4), 1'b1, 1'b0);
    chk("pre_rearm_ovf", 64'(ovf_a), 64'd1);
    do_arm();
    chk("rearm_state", 64'(state_a), 64'd1);
    chk("rearm_count", 64'(count_a), 64'd0);
    chk("rearm_ovf", 64'(ovf_a), 64'd0);
    chk("rearm_no_done", 64'(done_a), 64'd0);
    cap(32'h400, 1'b1, 1'b0);
    cap(32'h404, 1'b1, 1'b0);
    do_stop();
    chk("pre_reset_rd_valid", 64'(ia.rd_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    qa.delete(); qb.delete();
    chk("mid_drain_rst_state", 64'(state_a), 64'd0);
    chk("mid_drain_rst_count", 64'(count_b), 64'd0);
    chk("mid_drain_rst_rd_valid", 64'(ib.rd_valid), 64'd0);
    chk("mid_drain_rst_rd_pc", 64'(ib.rd_pc), 64'd0);
    chk("mid_drain_rst_rd_wb", 64'(ib.rd_wb), 64'd0);

    trig_en = 1'b1; trig_pc = 32'h500; post_cnt = 3'd0;
    do_arm();
    cap(32'h4FC, 1'b1, 1'b0);
    cap(32'h500, 1'b1, 1'b0);
    chk("post0_to_drain", 64'(state_a), 64'd3);
    drain(1'b0);

    trig_en = 1'b0;
    do_arm();
    cap(32'h600, 1'b1, 1'b0);
    cap(32'h604, 1'b0, 1'b1);
    chk("stop_cap_state", 64'(state_a), 64'd3);
    chk("stop_cap_count", 64'(count_a), 64'd1);
    drain(1'b0);

    do_arm();
    do_stop();
    chk("empty_drain_rd_valid", 64'(ia.rd_valid), 64'd0);
    drain(1'b0);

    do_arm();
    for (int i = 0; i < 12; i++) cap(32'h700 + 32'(i * 4), 1'b1, 1'b0);
    chk_ovf();
    do_stop();
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
